// File: rtl/awg_host_sequencer_pkg.sv
// awg_host_pkg: state encoding and default parameters for the AWG host sequencer
package awg_host_pkg;
  localparam int NUM_SIG_D = 12;
  localparam int MAX_SAMP_D = 128;
  localparam int STROBE_GAP_D = 2;
  localparam int RD_LAT_D = 2;
  typedef enum logic [3:0] {IDLE, CLEAR, LOAD, WGAP, RUN, SETTLE, READ, RWAIT, PUSH, DONE} state_t;
  function automatic int max2(int a, int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/awg_host_sequencer_if.sv
// awg_host_sequencer_if: pattern/capture streams and generator channel of the sequencer
interface awg_host_sequencer_if #(parameter int NUM_SIG = awg_host_pkg::NUM_SIG_D);
  logic [NUM_SIG-1:0] s_data, m_data, write_channel, read_channel;
  logic s_valid, s_ready, m_valid, m_ready;
  logic write_channel_wrStrobe, read_channel_rdStrobe, run, clear;
  modport master(
    input s_data, s_valid, m_ready, read_channel,
    output s_ready, m_data, m_valid, write_channel, write_channel_wrStrobe, read_channel_rdStrobe, run, clear
  );
  modport slave(
    output s_data, s_valid, m_ready, read_channel,
    input s_ready, m_data, m_valid, write_channel, write_channel_wrStrobe, read_channel_rdStrobe, run, clear
  );
endinterface

// File: rtl/awg_host_sequencer_counter.sv
// awg_host_counter: loadable down-counter that stops at zero, used for all timed waits
module awg_host_counter #(parameter int W = 16) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         zero
);
  logic [W-1:0] count;
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else count <= load ? value : zero ? count : count - 1'b1;
  assign zero = count == '0;
endmodule

// File: rtl/awg_host_sequencer.sv
// awg_host_sequencer: loads a pattern into the generator, runs it, then streams back the captures
module awg_host_sequencer import awg_host_pkg::*; #(
  parameter int NUM_SIG = NUM_SIG_D,
  parameter int MAX_SAMP = MAX_SAMP_D,
  parameter int STROBE_GAP = STROBE_GAP_D,
  parameter int RD_LAT = RD_LAT_D
) (
  input  logic        axi_clk,
  input  logic        axi_reset,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] n_samples,
  input  logic [15:0] settle_cycles,
  awg_host_sequencer_if.master bus,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err
);
  localparam int CW = $clog2(MAX_SAMP) + 1;
  localparam logic [15:0] WG = 16'(max2(STROBE_GAP, 1) - 1);
  localparam logic [15:0] RW = 16'(max2(max2(RD_LAT, STROBE_GAP), 1) - 1);
  state_t state, nxt;
  logic [CW-1:0] n, cnt;
  logic [15:0] lval;
  logic load, zero, ab, go, req, hs_s, hs_m, cap;
  awg_host_counter #(.W(16)) u_cnt (.clk(axi_clk), .rst(axi_reset), .load(load), .value(lval), .zero(zero));
  assign busy = state != IDLE;
  assign req = start && !abort;
  assign ab = abort && busy;
  assign go = req && !busy && n_samples != 0 && n_samples <= MAX_SAMP;
  assign bus.s_ready = state == LOAD && !abort;
  assign hs_s = bus.s_valid && bus.s_ready;
  assign hs_m = state == PUSH && bus.m_ready;
  assign cap = state == RWAIT && zero;
  always_comb begin
    nxt = state;
    load = 1'b0;
    lval = WG;
    case (state)
      IDLE:   nxt = go ? CLEAR : IDLE;
      CLEAR:  nxt = LOAD;
      LOAD:   begin nxt = hs_s ? WGAP : LOAD; load = hs_s; end
      WGAP:   nxt = !zero ? WGAP : cnt == n ? RUN : LOAD;
      RUN:    begin nxt = settle_cycles == 0 ? READ : SETTLE; load = 1'b1; lval = settle_cycles - 16'd1; end
      SETTLE: nxt = zero ? READ : SETTLE;
      READ:   begin nxt = RWAIT; load = 1'b1; lval = RW; end
      RWAIT:  nxt = zero ? PUSH : RWAIT;
      PUSH:   nxt = !hs_m ? PUSH : cnt == n ? DONE : READ;
      DONE:   nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (ab) nxt = IDLE;
  end
  // pulse outputs are registered from the next state so they coincide with the state they belong to
  always_ff @(posedge axi_clk or posedge axi_reset)
    if (axi_reset) begin
      state <= IDLE;
      n <= '0;
      cnt <= '0;
      err <= '0;
      done <= 1'b0;
      bus.m_valid <= 1'b0;
      bus.m_data <= '0;
      bus.write_channel <= '0;
      bus.write_channel_wrStrobe <= 1'b0;
      bus.read_channel_rdStrobe <= 1'b0;
      bus.run <= 1'b0;
      bus.clear <= 1'b0;
    end else begin
      state <= nxt;
      done <= nxt == DONE;
      bus.m_valid <= nxt == PUSH;
      bus.run <= nxt == RUN;
      bus.clear <= nxt == CLEAR || ab;
      bus.read_channel_rdStrobe <= nxt == READ;
      bus.write_channel_wrStrobe <= hs_s;
      if (hs_s) bus.write_channel <= NUM_SIG'(bus.s_data);
      if (cap) bus.m_data <= NUM_SIG'(bus.read_channel);
      if (go) n <= CW'(n_samples);
      if (req) err <= go ? 2'b00 : busy ? err | 2'b10 : err | 2'b01;
      if (go || state == RUN) cnt <= '0;
      else if (hs_s || cap) cnt <= cnt + 1'b1;
    end
endmodule

// File: tb/tb_awg_host_sequencer.sv
// tb_awg_host_sequencer: directed checks of load, run, settle, capture, stall, errors, abort and reset
module tb_awg_host_sequencer;
  localparam int N = 12;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, busy, done;
  logic [31:0] n_samples = '0;
  logic [15:0] settle_cycles = '0;
  logic [1:0] err;
  awg_host_sequencer_if #(.NUM_SIG(N)) bus();
  awg_host_sequencer #(.NUM_SIG(N), .MAX_SAMP(128), .STROBE_GAP(2), .RD_LAT(2)) dut (
    .axi_clk(clk), .axi_reset(rst), .start(start), .abort(abort), .n_samples(n_samples),
    .settle_cycles(settle_cycles), .bus(bus), .busy(busy), .done(done), .err(err)
  );
  always #5 clk = ~clk;

  logic [N-1:0] wv [256];
  logic [N-1:0] rv [256];
  logic [7:0] si = '0, ri = '0;
  logic p1 = 1'b0, prev_s = 1'b0;
  int cyc = 0, n_chk = 0, n_fail = 0, run_n = 0, rd_n = 0, clr_n = 0, done_n = 0, viol = 0, run_t = 0;
  int wt[$], rdt[$];
  logic [N-1:0] wq[$], mq[$];

  // source stream and generator with a real RD_LAT read latency
  assign bus.s_data = wv[si];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.s_valid && bus.s_ready) si <= si + 8'd1;
    p1 <= bus.read_channel_rdStrobe;
    if (p1) begin
      bus.read_channel <= rv[ri];
      ri <= ri + 8'd1;
    end else bus.read_channel <= 12'hABC;
  end

  always @(negedge clk) begin
    if (bus.write_channel_wrStrobe) begin wq.push_back(bus.write_channel); wt.push_back(cyc); end
    if (bus.read_channel_rdStrobe) begin rd_n++; rdt.push_back(cyc); end
    if (bus.run) begin run_n++; run_t = cyc; end
    if (bus.clear) clr_n++;
    if (done) done_n++;
    if (bus.m_valid && bus.m_ready) mq.push_back(bus.m_data);
    if ((bus.write_channel_wrStrobe || bus.read_channel_rdStrobe) && prev_s) viol++;
    if (bus.write_channel_wrStrobe && bus.read_channel_rdStrobe) viol++;
    prev_s = bus.write_channel_wrStrobe || bus.read_channel_rdStrobe;
  end

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input int n, input int s);
    n_samples = 32'(n);
    settle_cycles = 16'(s);
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int base, input int lim);
    int k = 0;
    while (done_n == base && k < lim) begin step(1); k++; end
    chk(tag, 64'(done_n - base), 1);
  endtask

  function automatic logic [33:0] outs();
    return {bus.s_ready, bus.m_valid, bus.m_data, bus.write_channel, bus.write_channel_wrStrobe,
            bus.read_channel_rdStrobe, bus.run, bus.clear, busy, done, err};
  endfunction

  initial begin
    int exp_w[6] = '{1, 3, 7, 15, 31, 63};
    int exp_r[8] = '{42, 85, 42, 85, 0, 127, 4095, 1};
    int wb, mb, rb, rnb, rdb, cb, db, k, bad;
    logic [N-1:0] v;
    for (int i = 0; i < 256; i++) begin wv[i] = N'(i * 37 + 5); rv[i] = N'(i * 7); end
    for (int i = 0; i < 6; i++) wv[i] = N'(exp_w[i]);
    for (int i = 0; i < 8; i++) rv[i] = N'(exp_r[i]);
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b0;
    step(3);
    chk("reset_outputs", 64'(outs()), 0);
    rst = 1'b0;
    step(2);
    chk("idle_after_reset", 64'(busy), 0);

    // six-word pattern, long settle, six captures
    bus.s_valid = 1'b1;
    bus.m_ready = 1'b1;
    wb = wq.size(); mb = mq.size(); rb = rdt.size(); rnb = run_n; cb = clr_n; db = done_n;
    pulse_start(6, 100);
    chk("a_busy", 64'(busy), 1);
    wait_done("a_done", db, 2000);
    step(3);
    chk("a_single_done", 64'(done_n - db), 1);
    chk("a_idle", 64'(busy), 0);
    chk("a_wr_count", 64'(wq.size() - wb), 6);
    for (int i = 0; i < 6; i++) chk("a_wr_value", 64'(wq[wb + i]), 64'(exp_w[i]));
    for (int i = 0; i < 5; i++) chk("a_wr_spacing", 64'(wt[wb + i + 1] - wt[wb + i]), 3);
    chk("a_run_count", 64'(run_n - rnb), 1);
    chk("a_run_after_last_wr", 64'(run_t - wt[wb + 5]), 2);
    chk("a_settle_100", 64'(rdt[rb] - run_t), 101);
    chk("a_clear_count", 64'(clr_n - cb), 1);
    chk("a_cap_count", 64'(mq.size() - mb), 6);
    for (int i = 0; i < 6; i++) chk("a_cap_value", 64'(mq[mb + i]), 64'(exp_r[i]));

    // back-pressure on the capture stream, zero settle
    bus.m_ready = 1'b0;
    mb = mq.size(); rb = rdt.size(); rdb = rd_n; db = done_n;
    pulse_start(2, 0);
    k = 0;
    while (!bus.m_valid && k < 200) begin step(1); k++; end
    chk("b_mvalid", 64'(bus.m_valid), 1);
    v = bus.m_data;
    chk("b_mdata", 64'(v), 12'hFFF);
    chk("b_settle_0", 64'(rdt[rb] - run_t), 1);
    bad = 0;
    repeat (10) begin
      step(1);
      if (!bus.m_valid || bus.m_data !== v) bad++;
    end
    chk("b_stall_stable", 64'(bad), 0);
    chk("b_no_extra_rd", 64'(rd_n - rdb), 1);
    bus.m_ready = 1'b1;
    step(1);
    chk("b_mvalid_fall", 64'(bus.m_valid), 0);
    wait_done("b_done", db, 200);
    chk("b_cap0", 64'(mq[mb]), 12'hFFF);
    chk("b_cap1", 64'(mq[mb + 1]), 12'h001);
    chk("b_rd_count", 64'(rd_n - rdb), 2);

    // illegal counts, largest legal count, start while busy
    cb = clr_n;
    pulse_start(0, 0);
    chk("c_err_zero", 64'(err), 1);
    chk("c_idle_zero", 64'(busy), 0);
    pulse_start(200, 0);
    chk("c_err_200", 64'(err), 1);
    chk("c_idle_200", 64'(busy), 0);
    pulse_start(129, 0);
    chk("c_err_129", 64'(err), 1);
    chk("c_idle_129", 64'(busy), 0);
    chk("c_no_clear", 64'(clr_n - cb), 0);
    wb = wq.size(); mb = mq.size(); db = done_n;
    pulse_start(128, 0);
    chk("c_err_cleared", 64'(err), 0);
    chk("c_busy_128", 64'(busy), 1);
    step(20);
    pulse_start(5, 0);
    chk("c_err_busy", 64'(err), 2);
    chk("c_still_busy", 64'(busy), 1);
    wait_done("c_done", db, 3000);
    chk("c_wr_count", 64'(wq.size() - wb), 128);
    chk("c_cap_count", 64'(mq.size() - mb), 128);
    chk("c_last_wr", 64'(wq[wb + 127]), 64'(wv[135]));
    chk("c_first_cap", 64'(mq[mb]), 64'(rv[8]));
    chk("c_last_cap", 64'(mq[mb + 127]), 64'(rv[135]));
    chk("c_err_sticky", 64'(err), 2);

    // abort during settle, then abort with start while idle
    rnb = run_n; rdb = rd_n; db = done_n;
    pulse_start(1, 100);
    k = 0;
    while (run_n == rnb && k < 100) begin step(1); k++; end
    chk("d_run_seen", 64'(run_n - rnb), 1);
    step(5);
    cb = clr_n;
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    chk("d_abort_idle", 64'(busy), 0);
    chk("d_abort_clear", 64'(bus.clear), 1);
    step(1);
    chk("d_clear_fall", 64'(bus.clear), 0);
    step(120);
    chk("d_no_done", 64'(done_n - db), 0);
    chk("d_no_rd", 64'(rd_n - rdb), 0);
    chk("d_clear_count", 64'(clr_n - cb), 1);
    cb = clr_n;
    abort = 1'b1;
    pulse_start(3, 0);
    abort = 1'b0;
    chk("d_abort_start_idle", 64'(busy), 0);
    step(3);
    chk("d_idle_abort_noclr", 64'(clr_n - cb), 0);
    chk("d_err_clean", 64'(err), 0);

    // asynchronous reset while waiting in LOAD
    bus.s_valid = 1'b0;
    pulse_start(3, 0);
    step(1);
    chk("e_in_load", 64'(bus.s_ready), 1);
    wb = wq.size(); rnb = run_n; cb = clr_n;
    rst = 1'b1;
    #1;
    chk("e_reset_outputs", 64'(outs()), 0);
    step(2);
    rst = 1'b0;
    bus.s_valid = 1'b1;
    step(10);
    chk("e_no_activity", 64'(wq.size() - wb + run_n - rnb + clr_n - cb), 0);
    chk("e_idle", 64'(busy), 0);

    chk("strobe_rules", 64'(viol), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/awg_host_sequencer.md
AWG_HOST_SEQUENCER -- requirements
Module: awg_host_sequencer

Interface
REQ-001 Parameter NUM_SIG, default 12: width of the pattern word and the capture word.
REQ-002 Parameter MAX_SAMP, default 128: largest legal sample count.
REQ-003 Parameter STROBE_GAP, default 2: idle cycles after every wrStrobe and after every rdStrobe.
REQ-004 Parameter RD_LAT, default 2: cycles from rdStrobe to valid read_channel data.
REQ-005 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-006 axi_clk  in  1  the single clock; all logic on its rising edge.
REQ-007 axi_reset  in  1  asynchronous, active-high reset.
REQ-008 start  in  1  one-cycle pulse that begins a sequence.
REQ-009 abort  in  1  one-cycle pulse that terminates any sequence.
REQ-010 n_samples  in  32  sample count, latched on an accepted start.
REQ-011 settle_cycles  in  16  cycles to wait after run before reads begin.
REQ-012 s_data / s_valid / s_ready  in NUM_SIG / in 1 / out 1  pattern-word input stream.
REQ-013 m_data / m_valid / m_ready  out NUM_SIG / out 1 / in 1  captured-word output stream.
REQ-014 write_channel  out  NUM_SIG  word driven to the generator.
REQ-015 write_channel_wrStrobe  out  1  one-cycle write strobe to the generator.
REQ-016 read_channel_rdStrobe  out  1  one-cycle read strobe to the generator.
REQ-017 read_channel  in  NUM_SIG  capture word returned by the generator.
REQ-018 run / clear  out 1 / out 1  one-cycle pulses to the generator.
REQ-019 busy  out  1  high whenever the FSM is not in IDLE.
REQ-020 done  out  1  one-cycle pulse when a sequence completes.
REQ-021 err  out  2  sticky flags: bit0 = bad count; bit1 = start while busy.

Function
REQ-022 FSM states SHALL be IDLE, CLEAR, LOAD, WGAP, RUN, SETTLE, READ, RWAIT, PUSH, DONE.
REQ-023 A start in IDLE with 1<=n_samples<=MAX_SAMP SHALL latch the count and go to CLEAR.
REQ-024 A start in IDLE with n_samples=0 or n_samples>MAX_SAMP SHALL set err[0] and leave the FSM in IDLE.
REQ-025 A start while busy SHALL set err[1] and SHALL otherwise be ignored.
REQ-026 CLEAR SHALL assert clear for exactly 1 cycle, then go to LOAD.
REQ-027 LOAD SHALL assert s_ready; on s_valid&&s_ready it SHALL register s_data onto write_channel and assert wrStrobe in the next cycle for exactly 1 cycle.
REQ-028 write_channel SHALL hold its value until the next write.
REQ-029 WGAP SHALL deassert s_ready for STROBE_GAP cycles; then it SHALL return to LOAD, or go to RUN once n words have been written.
REQ-030 RUN SHALL assert run for 1 cycle; SETTLE SHALL then wait settle_cycles cycles, where 0 means go to READ on the next cycle.
REQ-031 READ SHALL assert rdStrobe for 1 cycle; RWAIT SHALL wait max(RD_LAT, STROBE_GAP) cycles and then capture read_channel into m_data.
REQ-032 PUSH SHALL hold m_valid with m_data stable until m_ready; m_valid SHALL fall in the cycle after the handshake.
REQ-033 After n captures the FSM SHALL enter DONE, pulse done for 1 cycle, and return to IDLE.
REQ-034 Strobes SHALL never be asserted on consecutive cycles, and wrStrobe and rdStrobe SHALL never be asserted together.
REQ-035 Abort in any non-IDLE state SHALL take priority over all other transitions: it SHALL pulse clear for 1 cycle, drop m_valid and s_ready, and return to IDLE with no done pulse.
REQ-036 Abort in IDLE SHALL have no effect; abort and start in the same cycle SHALL resolve as abort only.
REQ-037 The sample counter SHALL be 8 bits wide ($clog2(MAX_SAMP)+1) and SHALL never wrap.
REQ-038 Only start (when idle and legal) and reset SHALL clear err.

Reset
REQ-039 axi_reset SHALL asynchronously force IDLE and drive every output to 0: s_ready, m_valid, m_data, write_channel, both strobes, run, clear, busy, done, err.
REQ-040 Reset asserted mid-sequence SHALL emit no further strobe, run, clear or done.

Structure
REQ-041 Package awg_host_pkg SHALL hold the state enum and the default parameter constants.
REQ-042 One sub-module awg_host_counter SHALL implement the loadable down-counter used for the gap, settle and RWAIT waits.

Verification
REQ-043 n_samples=6 with words 1,3,7,15,31,63 -> 6 wrStrobes with exactly those values, each separated by 2 idle cycles, then 1 run pulse.
REQ-044 Model returning 42,85,42,85,0,127 with settle_cycles=100 -> m_data sequence 42,85,42,85,0,127, then 1 done pulse.
REQ-045 m_ready held low for 10 cycles during PUSH -> m_valid and m_data stable, no extra rdStrobe.
REQ-046 start with n_samples=0, then n_samples=200 -> err=01 and FSM stays IDLE; start while busy -> err[1]=1 and the sequence continues.
REQ-047 abort during SETTLE -> 1 clear pulse, IDLE next cycle, no done; async reset during LOAD -> all outputs 0 immediately.
